// File: rtl/je_pkg.sv
// Shared types and sizing helpers for the camera-to-JPEG frame sequencer.
package je_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VS = 3'd1,
    CAPTURE = 3'd2,
    ENCODE  = 3'd3,
    READY   = 3'd4,
    RELEASE = 3'd5
  } je_state_t;

  // One YUYV pixel is two bytes.
  function automatic int frame_bytes(input int width, input int height);
    return 2 * width * height;
  endfunction

endpackage

// File: rtl/je_cam_capture.sv
// Camera byte capture: vsync edge detect, byte counter, short-frame flag and
// a registered frame-memory write one cycle behind each accepted byte.
module je_cam_capture
  import je_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 200,
  parameter int ASZ    = $clog2(HEIGHT) + $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           wait_vs,
  input  logic           capturing,
  input  logic           clear_err,
  input  logic           cam_vsync,
  input  logic           cam_href,
  input  logic           cam_byte_vld,
  input  logic [7:0]     cam_data,
  output logic           vs_rise,
  output logic           last_byte,
  output logic           cam_we,
  output logic [7:0]     cam_wdata,
  output logic [ASZ-1:0] cam_waddr,
  output logic           frame_err
);

  localparam int           FRAME_BYTES = frame_bytes(WIDTH, HEIGHT);
  localparam logic [ASZ:0] FB          = FRAME_BYTES[ASZ:0];
  localparam logic [ASZ:0] FB_LAST     = FB - 1'b1;

  logic         vsync_q;
  logic [ASZ:0] byte_cnt;
  logic         cnt_full;
  logic         cam_wr;
  logic         restart;

  assign vs_rise   = cam_vsync & ~vsync_q;
  assign cnt_full  = (byte_cnt >= FB);
  // A vsync edge in the same cycle as a byte wins; that byte is dropped.
  assign cam_wr    = capturing & ~vs_rise & cam_byte_vld & cam_href & ~cnt_full;
  assign last_byte = cam_wr & (byte_cnt == FB_LAST);
  assign restart   = capturing & vs_rise & ~cnt_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q   <= 1'b0;
      byte_cnt  <= '0;
      cam_we    <= 1'b0;
      cam_wdata <= '0;
      cam_waddr <= '0;
      frame_err <= 1'b0;
    end else begin
      vsync_q <= cam_vsync;
      cam_we  <= cam_wr;
      if (cam_wr) begin
        cam_wdata <= cam_data;
        cam_waddr <= byte_cnt[ASZ-1:0];
      end
      if (clear_err)
        frame_err <= 1'b0;
      else if (restart)
        frame_err <= 1'b1;
      if ((wait_vs && vs_rise) || restart)
        byte_cnt <= '0;
      else if (cam_wr)
        byte_cnt <= byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/je_frame_sequencer.sv
// Frame sequencer: capture one camera frame, run je_ip on it, hand the result
// to the host, and own the frame-memory write port throughout.
module je_frame_sequencer
  import je_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 200,
  parameter int ASZ    = $clog2(HEIGHT) + $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           img_req,
  output logic           img_rdy,
  output logic           frame_err,
  input  logic           cam_vsync,
  input  logic           cam_href,
  input  logic           cam_byte_vld,
  input  logic [7:0]     cam_data,
  output logic           conv_start,
  input  logic           conv_end,
  input  logic           je_we,
  input  logic [7:0]     je_wdata,
  input  logic [ASZ-1:0] je_waddr,
  output logic           mem_write_en,
  output logic [7:0]     mem_write_data,
  output logic [ASZ-1:0] mem_write_addr,
  output logic [2:0]     dbg_state
);

  // Host handshake is level based: img_req high asks for a frame, img_rdy
  // rises when the JPEG is in memory, and img_req falling releases je_ip; a
  // new request is only taken once je_ip has dropped conv_end.
  je_state_t      state, next_state;
  logic           conv_start_d, img_rdy_d;
  logic           vs_rise, last_byte;
  logic           cam_we;
  logic [7:0]     cam_wdata;
  logic [ASZ-1:0] cam_waddr;
  logic           clear_err;

  assign clear_err = (state == IDLE) & img_req & ~conv_end;
  assign dbg_state = state;

  je_cam_capture #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ASZ   (ASZ)
  ) u_cam_capture (
    .clk         (clk),
    .reset_n     (reset_n),
    .wait_vs     ((state == WAIT_VS) && img_req),
    .capturing   ((state == CAPTURE) && img_req),
    .clear_err   (clear_err),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_byte_vld(cam_byte_vld),
    .cam_data    (cam_data),
    .vs_rise     (vs_rise),
    .last_byte   (last_byte),
    .cam_we      (cam_we),
    .cam_wdata   (cam_wdata),
    .cam_waddr   (cam_waddr),
    .frame_err   (frame_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      conv_start <= 1'b0;
      img_rdy    <= 1'b0;
    end else begin
      state      <= next_state;
      conv_start <= conv_start_d;
      img_rdy    <= img_rdy_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (img_req && !conv_end) next_state = WAIT_VS;
      WAIT_VS: if (!img_req) next_state = IDLE;
               else if (vs_rise) next_state = CAPTURE;
      CAPTURE: if (!img_req) next_state = IDLE;
               else if (last_byte) next_state = ENCODE;
      // je_ip cannot abort, so img_req is not looked at until READY.
      ENCODE:  if (conv_end) next_state = READY;
      READY:   if (!img_req) next_state = RELEASE;
      RELEASE: if (!conv_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    conv_start_d = (next_state == ENCODE) || (next_state == READY);
    img_rdy_d    = (next_state == READY);
  end

  // The frame-completing camera write lands in the first ENCODE cycle and
  // outranks je_ip, which never writes in that cycle.
  always_comb begin
    mem_write_en   = 1'b0;
    mem_write_data = '0;
    mem_write_addr = '0;
    if (((state == CAPTURE) || (state == ENCODE)) && cam_we) begin
      mem_write_en   = 1'b1;
      mem_write_data = cam_wdata;
      mem_write_addr = cam_waddr;
    end else if ((state == ENCODE) || (state == READY)) begin
      mem_write_en   = je_we;
      mem_write_data = je_wdata;
      mem_write_addr = je_waddr;
    end
  end

endmodule

// File: tb/tb_je_frame_sequencer.sv
// Directed bench for je_frame_sequencer on a 20x6 frame (240 bytes).
module tb_je_frame_sequencer;
  import je_pkg::*;

  localparam int WIDTH  = 20;
  localparam int HEIGHT = 6;
  localparam int ASZ    = 8;
  localparam int FB     = 240;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           img_req, img_rdy, frame_err;
  logic           cam_vsync, cam_href, cam_byte_vld;
  logic [7:0]     cam_data;
  logic           conv_start, conv_end;
  logic           je_we;
  logic [7:0]     je_wdata;
  logic [ASZ-1:0] je_waddr;
  logic           mem_write_en;
  logic [7:0]     mem_write_data;
  logic [ASZ-1:0] mem_write_addr;
  logic [2:0]     dbg_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  typedef struct {
    string      name;
    int         short_bytes;
    int         abort_after;
    logic       je_wr;
    logic [7:0] je_addr;
    logic [7:0] je_data;
    logic       exp_err;
    logic       rereq;
  } vec_t;

  vec_t vecs[5];

  je_frame_sequencer #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ASZ   (ASZ)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .img_req       (img_req),
    .img_rdy       (img_rdy),
    .frame_err     (frame_err),
    .cam_vsync     (cam_vsync),
    .cam_href      (cam_href),
    .cam_byte_vld  (cam_byte_vld),
    .cam_data      (cam_data),
    .conv_start    (conv_start),
    .conv_end      (conv_end),
    .je_we         (je_we),
    .je_wdata      (je_wdata),
    .je_waddr      (je_waddr),
    .mem_write_en  (mem_write_en),
    .mem_write_data(mem_write_data),
    .mem_write_addr(mem_write_addr),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // je_ip stand-in: conv_end 50 cycles after conv_start, held 2 cycles past release.
  int conv_cnt, hold_cnt;
  initial begin
    conv_end = 1'b0;
    conv_cnt = 0;
    hold_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        conv_end = 1'b0;
        conv_cnt = 0;
        hold_cnt = 0;
      end else if (conv_start && !conv_end) begin
        conv_cnt++;
        if (conv_cnt == 50) conv_end = 1'b1;
      end else if (!conv_start && conv_end) begin
        hold_cnt++;
        if (hold_cnt == 3) begin
          conv_end = 1'b0;
          conv_cnt = 0;
          hold_cnt = 0;
        end
      end
    end
  end

  // Memory write monitor
  always @(negedge clk)
    if (mem_write_en === 1'b1) got_q.push_back({mem_write_addr, mem_write_data});

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      cam_byte_vld = 1'b1;
      cam_href     = 1'b1;
      cam_data     = 8'(i);
      exp_q.push_back({8'(i), 8'(i)});
      tick();
    end
    cam_byte_vld = 1'b0;
    cam_href     = 1'b0;
  endtask

  // Streams a full frame; returns one cycle into ENCODE.
  task automatic capture_frame(input string name);
    send_bytes(FB - 1);
    cam_byte_vld = 1'b1;
    cam_href     = 1'b1;
    cam_data     = 8'(FB - 1);
    exp_q.push_back({8'(FB - 1), 8'(FB - 1)});
    @(negedge clk);
    chk($sformatf("%s conv_start_early", name), 32'(conv_start), 32'd0);
    tick();
    cam_byte_vld = 1'b0;
    cam_href     = 1'b0;
    @(negedge clk);
    chk($sformatf("%s conv_start_rise", name), 32'(conv_start), 32'd1);
    chk($sformatf("%s state_encode", name), 32'(dbg_state), 32'(ENCODE));
    chk($sformatf("%s last_write_en", name), 32'(mem_write_en), 32'd1);
    chk($sformatf("%s last_write_addr", name), 32'(mem_write_addr), 32'(FB - 1));
  endtask

  // Scoreboard
  task automatic sb_compare(input string name);
    chk($sformatf("%s write_count", name), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s write[%0d]", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    got_q.delete();
    exp_q.delete();
    img_req = 1'b1;
    tick();
    chk($sformatf("%s state_wait_vs", v.name), 32'(dbg_state), 32'(WAIT_VS));
    chk($sformatf("%s err_cleared", v.name), 32'(frame_err), 32'd0);
    if (v.je_wr) begin
      je_we    = 1'b1;
      je_waddr = v.je_addr;
      je_wdata = v.je_data;
      @(negedge clk);
      chk($sformatf("%s je_blocked_wait_vs", v.name), 32'(mem_write_en), 32'd0);
      tick();
      je_we = 1'b0;
    end
    cam_vsync = 1'b1;
    tick();
    cam_vsync = 1'b0;
    chk($sformatf("%s state_capture", v.name), 32'(dbg_state), 32'(CAPTURE));

    if (v.abort_after > 0) begin
      send_bytes(v.abort_after);
      img_req      = 1'b0;
      cam_byte_vld = 1'b1;
      cam_href     = 1'b1;
      cam_data     = 8'h99;
      tick();
      chk($sformatf("%s state_idle", v.name), 32'(dbg_state), 32'(IDLE));
      for (int i = 0; i < 3; i++) tick();
      cam_byte_vld = 1'b0;
      cam_href     = 1'b0;
      chk($sformatf("%s no_conv_start", v.name), 32'(conv_start), 32'd0);
      chk($sformatf("%s stays_idle", v.name), 32'(dbg_state), 32'(IDLE));
      sb_compare(v.name);
      return;
    end

    if (v.short_bytes > 0) begin
      send_bytes(v.short_bytes);
      cam_vsync    = 1'b1;
      cam_byte_vld = 1'b1;
      cam_href     = 1'b1;
      cam_data     = 8'hEE;
      tick();
      cam_vsync    = 1'b0;
      cam_byte_vld = 1'b0;
      cam_href     = 1'b0;
      chk($sformatf("%s frame_err_set", v.name), 32'(frame_err), 32'd1);
      chk($sformatf("%s recapture", v.name), 32'(dbg_state), 32'(CAPTURE));
    end

    capture_frame(v.name);
    n = 0;
    if (v.je_wr) begin
      cam_byte_vld = 1'b1;
      cam_href     = 1'b1;
      cam_data     = 8'h77;
      repeat (4) begin tick(); n++; end
      je_we    = 1'b1;
      je_waddr = v.je_addr;
      je_wdata = v.je_data;
      exp_q.push_back({v.je_addr, v.je_data});
      @(negedge clk);
      chk($sformatf("%s je_addr", v.name), 32'(mem_write_addr), 32'(v.je_addr));
      chk($sformatf("%s je_data", v.name), 32'(mem_write_data), 32'(v.je_data));
      tick();
      n++;
      je_we = 1'b0;
      repeat (3) begin tick(); n++; end
      cam_byte_vld = 1'b0;
      cam_href     = 1'b0;
    end
    while (img_rdy !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk($sformatf("%s encode_cycles", v.name), 32'(n), 32'd50);
    chk($sformatf("%s img_rdy", v.name), 32'(img_rdy), 32'd1);
    chk($sformatf("%s conv_start_ready", v.name), 32'(conv_start), 32'd1);
    chk($sformatf("%s frame_err", v.name), 32'(frame_err), 32'(v.exp_err));

    img_req = 1'b0;
    tick();
    chk($sformatf("%s state_release", v.name), 32'(dbg_state), 32'(RELEASE));
    chk($sformatf("%s img_rdy_drop", v.name), 32'(img_rdy), 32'd0);
    chk($sformatf("%s conv_start_drop", v.name), 32'(conv_start), 32'd0);
    if (v.rereq) begin
      img_req = 1'b1;
      tick();
      chk($sformatf("%s held_off_1", v.name), 32'(dbg_state), 32'(RELEASE));
      tick();
      chk($sformatf("%s held_off_2", v.name), 32'(dbg_state), 32'(RELEASE));
      tick();
      chk($sformatf("%s back_idle", v.name), 32'(dbg_state), 32'(IDLE));
      tick();
      chk($sformatf("%s rereq_wait_vs", v.name), 32'(dbg_state), 32'(WAIT_VS));
      img_req = 1'b0;
      tick();
      chk($sformatf("%s rereq_drop", v.name), 32'(dbg_state), 32'(IDLE));
    end else begin
      n = 0;
      while (dbg_state !== 3'(IDLE) && n < 10) begin
        tick();
        n++;
      end
      chk($sformatf("%s release_cycles", v.name), 32'(n), 32'd3);
    end
    sb_compare(v.name);
  endtask

  initial begin
    vecs[0] = '{"nominal",   0,   0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{"short",     100, 0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{"abort",     0,  37, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{"write_mux", 0,   0, 1'b1, 8'h55, 8'hA5, 1'b0, 1'b0};
    vecs[4] = '{"release",   0,   0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};

    reset_n      = 1'b0;
    img_req      = 1'b0;
    cam_vsync    = 1'b0;
    cam_href     = 1'b0;
    cam_byte_vld = 1'b0;
    cam_data     = 8'h00;
    je_we        = 1'b0;
    je_wdata     = 8'h00;
    je_waddr     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset state", 32'(dbg_state), 32'(IDLE));
    chk("reset conv_start", 32'(conv_start), 32'd0);
    chk("reset img_rdy", 32'(img_rdy), 32'd0);
    chk("reset frame_err", 32'(frame_err), 32'd0);
    chk("reset mem_write_en", 32'(mem_write_en), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Reset while je_ip is writing in ENCODE.
    got_q.delete();
    exp_q.delete();
    img_req = 1'b1;
    tick();
    cam_vsync = 1'b1;
    tick();
    cam_vsync = 1'b0;
    capture_frame("rst_mid_encode");
    repeat (10) tick();
    je_we    = 1'b1;
    je_waddr = 8'h33;
    je_wdata = 8'h44;
    exp_q.push_back(16'h3344);
    @(negedge clk);
    chk("rst_mid_encode pre_write_en", 32'(mem_write_en), 32'd1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_encode conv_start", 32'(conv_start), 32'd0);
    chk("rst_mid_encode state", 32'(dbg_state), 32'(IDLE));
    chk("rst_mid_encode mem_write_en", 32'(mem_write_en), 32'd0);
    chk("rst_mid_encode img_rdy", 32'(img_rdy), 32'd0);
    img_req = 1'b0;
    je_we   = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_mid_encode after_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_mid_encode after_err", 32'(frame_err), 32'd0);
    chk("rst_mid_encode after_conv", 32'(conv_start), 32'd0);
    sb_compare("rst_mid_encode");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
